// File: rtl/cpc_meter.sv
// cpc_meter: windowed peak detector feeding a serial divider that yields cpc.
// Optional CPC_METER_SMOOTH_EN averages each new result with the previous cpc.
module cpc_meter #(
    parameter int VOL_BITS    = 23,
    parameter int CPC_BITS    = 15,
    parameter int NUM_DECIMAL = 8,
    parameter int WINDOW_LOG2 = 10,
    parameter int TARGET      = 1 << 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [VOL_BITS-1:0] sample,
    output logic [CPC_BITS-1:0]        cpc,
    output logic                       cpc_en,
    output logic                       cpc_stb,
    output logic                       overrun
);

    localparam int MW = VOL_BITS - 1;
    localparam int NW = MW + NUM_DECIMAL;
    localparam int CW = $clog2(NW);
    localparam logic [MW:0]   TGT  = (MW + 1)'(TARGET);
    localparam logic [CW-1:0] LAST = CW'(NW - 1);
    localparam logic [NW-1:0] QMAX = NW'((1 << CPC_BITS) - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [MW-1:0]           peak_q, peak_d;
    logic [WINDOW_LOG2-1:0]  cnt_q, cnt_d;
    logic [NW-1:0]           nq_q, nq_d;
    logic [MW-1:0]           rem_q, rem_d;
    logic [CW-1:0]           bit_q, bit_d;
    logic [CPC_BITS-1:0]     cpc_q, cpc_d;
    logic                    en_q, en_d;
    logic                    stb_q, stb_d;
    logic                    ovr_q, ovr_d;

    logic [MW-1:0]       neg;
    logic [MW-1:0]       mag;
    logic [MW-1:0]       win_peak;
    logic                win_end;
    logic [MW:0]         rem_sh;
    logic                ge;
    logic [CPC_BITS-1:0] q_sat;
`ifdef CPC_METER_SMOOTH_EN
    logic [CPC_BITS:0]   sum;
`endif

    // Low bits of the negation only depend on the low bits of the sample.
    assign neg = -sample[MW-1:0];

    always_comb begin
        mag = sample[MW-1:0];
        if (sample[VOL_BITS-1]) begin
            mag = (sample[MW-1:0] == '0) ? {MW{1'b1}} : neg;
        end
    end

    assign win_peak = (mag > peak_q) ? mag : peak_q;
    assign win_end  = sample_valid && (&cnt_q);
    assign rem_sh   = {rem_q, nq_q[NW-1]};
    assign ge       = (rem_sh >= TGT);
    assign q_sat    = (nq_q > QMAX) ? {CPC_BITS{1'b1}} : nq_q[CPC_BITS-1:0];
`ifdef CPC_METER_SMOOTH_EN
    assign sum      = {1'b0, cpc_q} + {1'b0, q_sat};
`endif

    always_comb begin
        state_d = state_q;
        peak_d  = peak_q;
        cnt_d   = cnt_q;
        nq_d    = nq_q;
        rem_d   = rem_q;
        bit_d   = bit_q;
        cpc_d   = cpc_q;
        en_d    = en_q;
        stb_d   = 1'b0;
        ovr_d   = ovr_q;

        if (sample_valid) begin
            cnt_d  = cnt_q + 1'b1;
            peak_d = win_end ? '0 : win_peak;
        end
        if (win_end && state_q != IDLE) begin
            ovr_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (win_end) begin
                    nq_d    = {win_peak, {NUM_DECIMAL{1'b0}}};
                    rem_d   = '0;
                    bit_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = MW'(ge ? rem_sh - TGT : rem_sh);
                nq_d  = {nq_q[NW-2:0], ge};
                bit_d = bit_q + 1'b1;
                if (bit_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef CPC_METER_SMOOTH_EN
                cpc_d = en_q ? CPC_BITS'(sum >> 1) : q_sat;
`else
                cpc_d = q_sat;
`endif
                stb_d   = 1'b1;
                en_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            peak_q  <= '0;
            cnt_q   <= '0;
            nq_q    <= '0;
            rem_q   <= '0;
            bit_q   <= '0;
            cpc_q   <= '0;
            en_q    <= 1'b0;
            stb_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            peak_q  <= peak_d;
            cnt_q   <= cnt_d;
            nq_q    <= nq_d;
            rem_q   <= rem_d;
            bit_q   <= bit_d;
            cpc_q   <= cpc_d;
            en_q    <= en_d;
            stb_q   <= stb_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cpc     = cpc_q;
    assign cpc_en  = en_q;
    assign cpc_stb = stb_q;
    assign overrun = ovr_q;

endmodule
